// File: rtl/p2m_dispatch.sv
// p2m_dispatch: assembles multi-beat pipe messages and dispatches them to one of NUM_METHODS method ports.
module p2m_dispatch #(
  parameter int NUM_METHODS   = 3,
  parameter int BEAT_WIDTH    = 32,
  parameter int MAX_BEATS     = 4,
  parameter int PAYLOAD_WIDTH = BEAT_WIDTH * MAX_BEATS
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     pipe_enq__ENA,
  input  logic [BEAT_WIDTH-1:0]    pipe_enq_v,
  output logic                     pipe_enq__RDY,
  output logic [NUM_METHODS-1:0]   method__ENA,
  output logic [PAYLOAD_WIDTH-1:0] method_payload,
  input  logic [NUM_METHODS-1:0]   method__RDY,
  output logic [15:0]              err_count,
  output logic [15:0]              err_id
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPATCH, DRAIN} state_t;
  localparam logic [15:0] NM = 16'(NUM_METHODS);
  localparam logic [15:0] MB = 16'(MAX_BEATS);
  state_t state;
  logic [15:0] id, len, k, remaining;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic fire, bad;
  logic [15:0] hdr_id, hdr_len;
  assign pipe_enq__RDY = state != DISPATCH;
  assign fire = pipe_enq__ENA & pipe_enq__RDY;
  assign hdr_id = pipe_enq_v[31:16];
  assign hdr_len = pipe_enq_v[15:0];
  assign bad = hdr_id >= NM || hdr_len > MB;
  assign method_payload = payload;
  // Only method__RDY and registered state reach the enables.
  always_comb begin
    method__ENA = '0;
    for (int i = 0; i < NUM_METHODS; i++)
      method__ENA[i] = state == DISPATCH && id == 16'(i) && method__RDY[i];
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      id <= '0;
      len <= '0;
      k <= '0;
      remaining <= '0;
      payload <= '0;
      err_count <= '0;
      err_id <= '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          id <= hdr_id;
          len <= hdr_len;
          k <= '0;
          payload <= '0;
          if (bad) begin
            err_count <= &err_count ? err_count : err_count + 16'd1;
            err_id <= hdr_id;
            remaining <= hdr_len;
            state <= hdr_len == 16'd0 ? IDLE : DRAIN;
          end else
            state <= hdr_len == 16'd0 ? DISPATCH : COLLECT;
        end
        COLLECT: if (fire) begin
          for (int j = 0; j < MAX_BEATS; j++)
            if (k == 16'(j)) payload[j*BEAT_WIDTH +: BEAT_WIDTH] <= pipe_enq_v;
          k <= k + 16'd1;
          if (k == len - 16'd1) state <= DISPATCH;
        end
        DISPATCH: if (|method__ENA) state <= IDLE;
        DRAIN: if (fire) begin
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_p2m_dispatch.sv
// tb_p2m_dispatch: scoreboard bench; a message-level model queues expected dispatches, a monitor pops them.
module tb_p2m_dispatch;
  logic CLK = 0, nRST = 0, enq_ena = 0;
  logic [31:0] enq_v = 0;
  logic enq_rdy;
  logic [2:0] m_ena, m_rdy = 3'b111;
  logic [127:0] payload;
  logic [15:0] err_count, err_id;
  int vectors = 0, miscompares = 0;
  logic [2:0] exp_ena_q[$];
  logic [127:0] exp_pl_q[$];
  logic [31:0] beats[8];
  logic [15:0] m_err = 0, m_errid = 0;
  bit rand_rdy = 0;

  p2m_dispatch dut (
    .CLK(CLK), .nRST(nRST),
    .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(enq_rdy),
    .method__ENA(m_ena), .method_payload(payload), .method__RDY(m_rdy),
    .err_count(err_count), .err_id(err_id)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) if (rand_rdy) m_rdy = 3'($urandom);

  // Monitor: every enable pulse must match the oldest outstanding message.
  always @(negedge CLK) begin
    #2;
    if (nRST && |m_ena) begin
      if (exp_ena_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_dispatch: got ena %b expected none", m_ena);
      end else begin
        check("dispatch_ena", 128'(m_ena), 128'(exp_ena_q.pop_front()));
        check("dispatch_payload", payload, exp_pl_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [31:0] v);
    int g = 0;
    enq_ena = 1;
    enq_v = v;
    while (!enq_rdy && g < 200) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 200) check("enq_timeout", 128'(g), 128'(0));
    @(negedge CLK);
    enq_ena = 0;
  endtask

  task automatic send_msg(input int mid, input int len, input int nb);
    logic [127:0] pl = '0;
    if (mid >= 3 || len > 4) begin
      m_err = m_err == 16'hFFFF ? m_err : m_err + 16'd1;
      m_errid = 16'(mid);
    end else begin
      for (int j = 0; j < len; j++) pl[j*32 +: 32] = beats[j];
      exp_ena_q.push_back(3'b001 << mid);
      exp_pl_q.push_back(pl);
    end
    send_beat({16'(mid), 16'(len)});
    for (int j = 0; j < nb; j++) send_beat(beats[j]);
  endtask

  task automatic wait_empty(input string name);
    int g = 0;
    while (exp_ena_q.size() != 0 && g < 500) begin
      @(negedge CLK);
      g++;
    end
    check(name, 128'(exp_ena_q.size()), 128'(0));
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_ena", 128'(m_ena), 128'(0));
    check("rst_err_count", 128'(err_count), 128'(0));
    check("rst_err_id", 128'(err_id), 128'(0));
    check("rst_enq_rdy", 128'(enq_rdy), 128'(1));
    check("rst_payload", payload, 128'(0));
    nRST = 1;
    @(negedge CLK);

    beats[0] = 32'hDEADBEEF;
    send_msg(1, 1, 1);
    check("t1_latency_ena", 128'(m_ena), 128'(3'b010));
    @(negedge CLK);

    m_rdy = 3'b011;
    for (int j = 0; j < 4; j++) beats[j] = 32'(j + 1);
    send_msg(2, 4, 4);
    repeat (5) begin
      check("t2_stall_enq_rdy", 128'(enq_rdy), 128'(0));
      check("t2_stall_ena", 128'(m_ena), 128'(0));
      @(negedge CLK);
    end
    m_rdy = 3'b111;
    #1 check("t2_fire_ena", 128'(m_ena), 128'(3'b100));
    @(negedge CLK);
    check("t2_after_ena", 128'(m_ena), 128'(0));
    check("t2_after_enq_rdy", 128'(enq_rdy), 128'(1));

    send_msg(0, 0, 0);
    check("t3_zero_len_ena", 128'(m_ena), 128'(3'b001));
    @(negedge CLK);

    beats[0] = 32'h1111_2222;
    beats[1] = 32'h3333_4444;
    send_msg(7, 2, 2);
    check("t4_err_count", 128'(err_count), 128'(1));
    check("t4_err_id", 128'(err_id), 128'(7));
    beats[0] = $urandom;
    send_msg(0, 1, 1);
    @(negedge CLK);

    for (int j = 0; j < 5; j++) beats[j] = $urandom;
    send_msg(1, 5, 5);
    check("t5_err_count", 128'(err_count), 128'(2));
    check("t5_err_id", 128'(err_id), 128'(1));
    for (int j = 0; j < 3; j++) beats[j] = $urandom;
    send_msg(2, 3, 3);
    wait_empty("directed_queue_empty");

    rand_rdy = 1;
    repeat (40) begin
      int mid, len;
      mid = $urandom_range(0, 9) < 8 ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 65535));
      len = $urandom_range(0, 6);
      for (int j = 0; j < 8; j++) beats[j] = $urandom;
      send_msg(mid, len, len);
      check("rand_err_count", 128'(err_count), 128'(m_err));
      check("rand_err_id", 128'(err_id), 128'(m_errid));
    end
    wait_empty("rand_queue_empty");
    rand_rdy = 0;
    @(negedge CLK);
    m_rdy = 3'b111;

    beats[0] = 32'hAAAA_0001;
    beats[1] = 32'hAAAA_0002;
    send_beat({16'd2, 16'd4});
    send_beat(beats[0]);
    send_beat(beats[1]);
    nRST = 0;
    #1;
    check("mid_rst_ena", 128'(m_ena), 128'(0));
    check("mid_rst_err_count", 128'(err_count), 128'(0));
    check("mid_rst_err_id", 128'(err_id), 128'(0));
    check("mid_rst_payload", payload, 128'(0));
    check("mid_rst_enq_rdy", 128'(enq_rdy), 128'(1));
    m_err = 0;
    m_errid = 0;
    @(negedge CLK);
    nRST = 1;
    @(negedge CLK);
    beats[0] = 32'h5555_6666;
    beats[1] = 32'h7777_8888;
    send_msg(1, 2, 2);
    wait_empty("post_rst_queue_empty");
    check("post_rst_err_count", 128'(err_count), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
